// File: rtl/memory_system_if.sv
// memory_system_if -- CPU-side bus of the 8-bit memory subsystem.
//   address  : 8-bit memory/port address
//   data_in  : write data
//   write    : write enable, acts on the rising edge
//   data_out : registered read data, one clock after the address
// slave modport is used by memory_system; master by the CPU (or a bench).
interface memory_system_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       write;
  logic [7:0] data_out;

  modport slave  (input  address, data_in, write, output data_out);
  modport master (output address, data_in, write, input  data_out);
endinterface

// File: rtl/memory_system.sv
// memory_system -- unified 8-bit memory: ROM, RAM, output and input ports.
//   clk            : system clock, all state on rising edge
//   reset          : synchronous, active-high; clears data_out, RAM, out ports
//   bus            : memory_system_if.slave (address, data_in, write, data_out)
//   port_in_00..15 : external inputs, read at 0xF0..0xFF
//   port_out_00..15: registered outputs, written/read at 0xE0..0xEF
// Map: 0x00-0x7F ROM, 0x80-0xDF RAM (96 x 8), 0xE0-0xEF out, 0xF0-0xFF in.
module memory_system (
  input  logic                  clk,
  input  logic                  reset,
  memory_system_if.slave        bus,
  input  logic [7:0]            port_in_00, port_in_01, port_in_02, port_in_03,
  input  logic [7:0]            port_in_04, port_in_05, port_in_06, port_in_07,
  input  logic [7:0]            port_in_08, port_in_09, port_in_10, port_in_11,
  input  logic [7:0]            port_in_12, port_in_13, port_in_14, port_in_15,
  output logic [7:0]            port_out_00, port_out_01, port_out_02, port_out_03,
  output logic [7:0]            port_out_04, port_out_05, port_out_06, port_out_07,
  output logic [7:0]            port_out_08, port_out_09, port_out_10, port_out_11,
  output logic [7:0]            port_out_12, port_out_13, port_out_14, port_out_15
);
  localparam int RAM_DEPTH = 96;

  logic [15:0][7:0] port_in_w;
  logic [15:0][7:0] port_out_q;
  logic [7:0]       ram_q [RAM_DEPTH];
  logic [7:0]       data_out_q, data_out_d;
  logic [7:0]       rom_data;
  logic             is_rom, is_ram, is_out;

  assign port_in_w = {port_in_15, port_in_14, port_in_13, port_in_12,
                      port_in_11, port_in_10, port_in_09, port_in_08,
                      port_in_07, port_in_06, port_in_05, port_in_04,
                      port_in_03, port_in_02, port_in_01, port_in_00};

  assign {port_out_15, port_out_14, port_out_13, port_out_12,
          port_out_11, port_out_10, port_out_09, port_out_08,
          port_out_07, port_out_06, port_out_05, port_out_04,
          port_out_03, port_out_02, port_out_01, port_out_00} = port_out_q;

  assign bus.data_out = data_out_q;

  // Region decode; the remaining region (0xF0-0xFF) is the input ports.
  assign is_rom = ~bus.address[7];
  assign is_ram = bus.address[7] & (bus.address[6:5] != 2'b11);
  assign is_out = bus.address[7:4] == 4'hE;

  always_comb begin
    rom_data = 8'h00;
    case (bus.address[6:0])
      7'h00:   rom_data = 8'h86;
      7'h01:   rom_data = 8'hAA;
      7'h02:   rom_data = 8'h96;
      7'h03:   rom_data = 8'hE0;
      7'h04:   rom_data = 8'h20;
      default: rom_data = 8'h00;
    endcase
  end

  // Read mux sees pre-write contents, giving read-first behaviour on writes.
  // RAM index is address-0x80, i.e. the low 7 address bits (0..95).
  always_comb begin
    data_out_d = port_in_w[bus.address[3:0]];
    if (is_rom)      data_out_d = rom_data;
    else if (is_ram) data_out_d = ram_q[bus.address[6:0]];
    else if (is_out) data_out_d = port_out_q[bus.address[3:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= 8'h00;
      port_out_q <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
    end else begin
      data_out_q <= data_out_d;
      if (bus.write && is_ram) ram_q[bus.address[6:0]]       <= bus.data_in;
      if (bus.write && is_out) port_out_q[bus.address[3:0]] <= bus.data_in;
    end
  end
endmodule

// File: tb/tb_memory_system.sv
// tb_memory_system -- directed plan plus random traffic against a
// behavioural model of the memory map (arrays indexed by region offset).
module tb_memory_system;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pin  [16];
  logic [7:0] pout [16];

  // Reference model state
  logic [7:0] m_ram  [96];
  logic [7:0] m_pout [16];
  logic [7:0] m_do;

  int n_chk  = 0;
  int n_fail = 0;

  memory_system_if bus ();

  always #5 clk = ~clk;

  memory_system dut (
    .clk(clk), .reset(reset), .bus(bus),
    .port_in_00(pin[0]),   .port_in_01(pin[1]),   .port_in_02(pin[2]),   .port_in_03(pin[3]),
    .port_in_04(pin[4]),   .port_in_05(pin[5]),   .port_in_06(pin[6]),   .port_in_07(pin[7]),
    .port_in_08(pin[8]),   .port_in_09(pin[9]),   .port_in_10(pin[10]),  .port_in_11(pin[11]),
    .port_in_12(pin[12]),  .port_in_13(pin[13]),  .port_in_14(pin[14]),  .port_in_15(pin[15]),
    .port_out_00(pout[0]), .port_out_01(pout[1]), .port_out_02(pout[2]), .port_out_03(pout[3]),
    .port_out_04(pout[4]), .port_out_05(pout[5]), .port_out_06(pout[6]), .port_out_07(pout[7]),
    .port_out_08(pout[8]), .port_out_09(pout[9]), .port_out_10(pout[10]), .port_out_11(pout[11]),
    .port_out_12(pout[12]), .port_out_13(pout[13]), .port_out_14(pout[14]), .port_out_15(pout[15])
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rom_val(input int a);
    case (a)
      0: return 8'h86;
      1: return 8'hAA;
      2: return 8'h96;
      3: return 8'hE0;
      4: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a < 'h80)      return rom_val(a);
    else if (a < 'hE0) return m_ram[a - 'h80];
    else if (a < 'hF0) return m_pout[a - 'hE0];
    else               return pin[a - 'hF0];
  endfunction

  // One clock: drive, advance the model on the edge, check just after it.
  task automatic step(input logic r, input logic [7:0] a, input logic w, input logic [7:0] d);
    int ai;
    reset = r; bus.address = a; bus.write = w; bus.data_in = d;
    @(posedge clk);
    ai = int'(a);
    if (r) begin
      m_do = 8'h00;
      foreach (m_ram[i])  m_ram[i]  = 8'h00;
      foreach (m_pout[i]) m_pout[i] = 8'h00;
    end else begin
      m_do = m_read(ai);
      if (w && ai >= 'h80 && ai < 'hE0) m_ram[ai - 'h80] = d;
      if (w && ai >= 'hE0 && ai < 'hF0) m_pout[ai - 'hE0] = d;
    end
    #1;
    chk($sformatf("data_out@%02h", a), bus.data_out, m_do);
    for (int i = 0; i < 16; i++) chk($sformatf("port_out_%0d", i), pout[i], m_pout[i]);
  endtask

  initial begin
    foreach (pin[i])    pin[i]    = 8'h00;
    foreach (m_ram[i])  m_ram[i]  = 8'hXX;
    foreach (m_pout[i]) m_pout[i] = 8'hXX;
    m_do = 8'hXX;
    reset = 1'b1; bus.address = 8'h00; bus.write = 1'b0; bus.data_in = 8'h00;
    #2;

    // Reset, then RAM reads back cleared
    step(1, 8'h82, 0, 8'h00);
    step(0, 8'h82, 0, 8'h00);
    // RAM writes incl. both region edges
    step(0, 8'h82, 1, 8'h55);
    step(0, 8'h82, 0, 8'h00);
    step(0, 8'h80, 1, 8'h11);
    step(0, 8'hDF, 1, 8'h22);
    step(0, 8'h80, 0, 8'h00);
    step(0, 8'hDF, 0, 8'h00);
    // ROM reads and ignored ROM write
    step(0, 8'h00, 0, 8'h00);
    step(0, 8'h01, 0, 8'h00);
    step(0, 8'h05, 0, 8'h00);
    step(0, 8'h7F, 0, 8'h00);
    step(0, 8'h05, 1, 8'hFF);
    step(0, 8'h05, 0, 8'h00);
    // Input ports
    pin[0] = 8'hAA; pin[1] = 8'hBB; pin[15] = 8'hFF;
    step(0, 8'hF0, 0, 8'h00);
    step(0, 8'hF1, 0, 8'h00);
    step(0, 8'hFF, 0, 8'h00);
    pin[0] = 8'h12;
    step(0, 8'hF0, 0, 8'h00);
    step(0, 8'hF0, 1, 8'h5A);
    step(0, 8'hF0, 0, 8'h00);
    // Output ports
    step(0, 8'hE0, 1, 8'h33);
    step(0, 8'hE1, 1, 8'h44);
    step(0, 8'hEF, 1, 8'h77);
    step(0, 8'hE1, 0, 8'h00);
    // Reset beats write; read-first on back-to-back writes
    step(1, 8'h90, 1, 8'hAB);
    step(0, 8'h90, 0, 8'h00);
    step(0, 8'h90, 1, 8'h66);
    step(0, 8'h90, 1, 8'h99);
    step(0, 8'h90, 0, 8'h00);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) pin[$urandom_range(0, 15)] = 8'($urandom);
      step(($urandom_range(0, 49) == 0), 8'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
